// File: rtl/pipe_alu_hs.sv
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
// S1 registers the incoming operation; S2 registers the computed result, flags and tag.
// Each stage accepts new data whenever it is empty or its downstream is draining,
// so bubbles collapse and backpressure propagates one stage per cycle.
module pipe_alu_hs #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic [3:0]        out_flags,
  output logic [CNT_W-1:0]  op_count
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpSll  = 4'd5;
  localparam logic [3:0] OpSrl  = 4'd6;
  localparam logic [3:0] OpSra  = 4'd7;
  localparam logic [3:0] OpPass = 4'd8;

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Stage 1 registers
  logic              s1_valid;
  logic [3:0]        s1_op;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [TAG_W-1:0]  s1_tag;

  // Stage 2 valid; its payload lives directly in the out_* registers
  logic              s2_valid;

  logic s1_ready;
  logic s2_ready;
  logic in_fire;
  logic out_fire;

  // Execute-stage combinational results
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] alu_result;
  logic              alu_err;
  logic              alu_ovf;
  logic              alu_carry;
  logic              alu_zero;

  // Ready chain and transfer strobes
  always_comb begin
    s2_ready  = !s2_valid || out_ready;
    s1_ready  = !s1_valid || s2_ready;
    in_ready  = s1_ready;
    out_valid = s2_valid;
    in_fire   = in_valid && in_ready;
    out_fire  = s2_valid && out_ready;
  end

  // ALU evaluated on the S1 contents
  always_comb begin
    sum        = {1'b0, s1_a} + {1'b0, s1_b};
    diff       = {1'b0, s1_a} - {1'b0, s1_b};
    shamt      = s1_b[SH_W-1:0];
    alu_result = '0;
    alu_err    = 1'b0;
    alu_ovf    = 1'b0;
    alu_carry  = 1'b0;
    case (s1_op)
      OpAdd: begin
        alu_result = sum[DATA_W-1:0];
        alu_carry  = sum[DATA_W];
        // Same-sign operands producing an opposite-sign sum
        alu_ovf    = (s1_a[DATA_W-1] == s1_b[DATA_W-1]) &&
                     (sum[DATA_W-1] != s1_a[DATA_W-1]);
      end
      OpSub: begin
        alu_result = diff[DATA_W-1:0];
        alu_carry  = diff[DATA_W];  // borrow: a < b unsigned
        alu_ovf    = (s1_a[DATA_W-1] != s1_b[DATA_W-1]) &&
                     (diff[DATA_W-1] != s1_a[DATA_W-1]);
      end
      OpAnd:  alu_result = s1_a & s1_b;
      OpOr:   alu_result = s1_a | s1_b;
      OpXor:  alu_result = s1_a ^ s1_b;
      OpSll:  alu_result = s1_a << shamt;
      OpSrl:  alu_result = s1_a >> shamt;
      OpSra:  alu_result = $unsigned($signed(s1_a) >>> shamt);
      OpPass: alu_result = s1_a;
      default: alu_err   = 1'b1;
    endcase
    alu_zero = (alu_result == '0);
  end

  // Stage 1: capture on input transfer, drain when S2 takes the entry
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_tag   <= in_tag;
    end else if (s2_ready) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: load the ALU result when free, otherwise hold outputs stable
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_flags  <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_result <= alu_result;
        out_tag    <= s1_tag;
        out_flags  <= {alu_err, alu_ovf, alu_carry, alu_zero};
      end
    end
  end

  // Saturating count of retired results
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      op_count <= '0;
    end else if (out_fire && (op_count != CntMax)) begin
      op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_alu_hs.sv
// Directed bench for pipe_alu_hs: latency, opcodes/flags, backpressure,
// reset mid-flight and a randomised streaming run against a reference model.
module tb_pipe_alu_hs;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [3:0]  out_tag;
  logic [3:0]  out_flags;
  logic [15:0] op_count;

  // Second instance with a narrow counter sharing the same stimulus
  logic        s_in_ready;
  logic        s_out_valid;
  logic [31:0] s_out_result;
  logic [3:0]  s_out_tag;
  logic [3:0]  s_out_flags;
  logic [3:0]  s_op_count;

  int n_cmp  = 0;
  int n_fail = 0;

  pipe_alu_hs #(.DATA_W(32), .TAG_W(4), .CNT_W(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags),
    .op_count   (op_count)
  );

  pipe_alu_hs #(.DATA_W(32), .TAG_W(4), .CNT_W(4)) dut_sat (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (s_in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_tag     (in_tag),
    .out_valid  (s_out_valid),
    .out_ready  (out_ready),
    .out_result (s_out_result),
    .out_tag    (s_out_tag),
    .out_flags  (s_out_flags),
    .op_count   (s_op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock: past the rising edge, settled just after the falling edge
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference model: returns {flags, result}, flags = {err, ovf, carry, zero}
  function automatic logic [35:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] wide;
    longint      sa, sb, sr;
    logic        e, v, c;
    logic [4:0]  sh;
    e = 1'b0; v = 1'b0; c = 1'b0; r = '0;
    sa = $signed(a);
    sb = $signed(b);
    sh = b[4:0];
    case (op)
      4'd0: begin
        wide = {32'd0, a} + {32'd0, b};
        r = wide[31:0];
        c = wide[32];
        sr = sa + sb;
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd1: begin
        r = a - b;
        c = (a < b);
        sr = sa - sb;
        v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << sh;
      4'd6: r = a >> sh;
      4'd7: begin
        sr = sa >>> sh;
        r = sr[31:0];
      end
      4'd8: r = a;
      default: e = 1'b1;
    endcase
    return {e, v, c, (r == 32'd0), r};
  endfunction

  // One isolated operation with out_ready=1; result checked two cycles after transfer
  task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] tag,
                        input logic [31:0] exp_r, input logic [3:0] exp_f);
    in_op = op; in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
    #1;
    chk({name, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    tick();
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_result"}, out_result, exp_r);
    chk({name, "_flags"}, out_flags, exp_f);
    chk({name, "_tag"}, out_tag, tag);
    tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  logic [3:0]  st_op  [100];
  logic [31:0] st_a   [100];
  logic [31:0] st_b   [100];
  logic [39:0] exp_q  [$];  // {tag, flags, result}
  logic [39:0] front;
  logic [31:0] held_r;
  int          sent, recv, cycles;

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0; in_tag = '0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_op_count", op_count, 0);
    chk("rst_result", out_result, 0);
    chk("rst_flags", out_flags, 0);
    chk("rst_tag", out_tag, 0);

    // Latency: ADD 0xFFFFFFFF + 1, visible in the second cycle after the transfer
    in_op = 4'd0; in_a = 32'hFFFF_FFFF; in_b = 32'd1; in_tag = 4'd3; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("lat_cycle1_valid", out_valid, 0);
    tick();
    chk("lat_cycle2_valid", out_valid, 1);
    chk("add_wrap_result", out_result, 32'h0);
    chk("add_wrap_flags", out_flags, 4'b0011);
    chk("add_wrap_tag", out_tag, 4'd3);
    chk("add_wrap_cnt_before", op_count, 0);
    tick();
    chk("add_wrap_cnt", op_count, 1);
    chk("add_wrap_drained", out_valid, 0);

    run_op("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1,         4'd1, 32'h8000_0000, 4'b0100);
    run_op("add_cy",  4'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2, 32'hFFFF_FFFE, 4'b0010);
    run_op("sub_ovf", 4'd1, 32'h8000_0000, 32'h1,         4'd3, 32'h7FFF_FFFF, 4'b0100);
    run_op("sub_brw", 4'd1, 32'h2,         32'h5,         4'd4, 32'hFFFF_FFFD, 4'b0010);
    run_op("sra",     4'd7, 32'h8000_0000, 32'h21,        4'd5, 32'hC000_0000, 4'b0000);
    run_op("sll",     4'd5, 32'h1,         32'd31,        4'd6, 32'h8000_0000, 4'b0000);
    run_op("illegal", 4'd12, 32'h5,        32'h6,         4'd7, 32'h0,         4'b1001);
    run_op("srl",     4'd6, 32'h8000_0000, 32'h4,         4'd8, 32'h0800_0000, 4'b0000);
    run_op("xor",     4'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd9, 32'h0FF0_0FF0, 4'b0000);
    run_op("and",     4'd2, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'd10, 32'h0,        4'b0001);
    run_op("or",      4'd3, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 4'd11, 32'hFFFF_FFFF, 4'b0000);
    run_op("pass",    4'd8, 32'h1234_5678, 32'hFFFF_FFFF, 4'd12, 32'h1234_5678, 4'b0000);
    chk("directed_op_count", op_count, 13);

    // Backpressure: three PASS ops (tags 1,2,3) with out_ready=0
    do_reset();
    out_ready = 1'b0;
    in_op = 4'd8; in_b = '0; in_valid = 1'b1;
    in_a = 32'h11; in_tag = 4'd1;
    #1;
    chk("bp_accept1", in_ready, 1);
    tick();
    in_a = 32'h22; in_tag = 4'd2;
    chk("bp_accept2", in_ready, 1);
    tick();
    in_a = 32'h33; in_tag = 4'd3;
    chk("bp_full_ready", in_ready, 0);
    chk("bp_full_valid", out_valid, 1);
    chk("bp_head_tag", out_tag, 4'd1);
    held_r = out_result;
    tick();
    tick();
    chk("bp_hold_ready", in_ready, 0);
    chk("bp_hold_tag", out_tag, 4'd1);
    chk("bp_hold_result", out_result, held_r);
    chk("bp_hold_count", op_count, 0);
    // Release: input and output transfer together on a full pipe
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("bp_out2_tag", out_tag, 4'd2);
    chk("bp_out2_result", out_result, 32'h22);
    tick();
    chk("bp_out3_tag", out_tag, 4'd3);
    chk("bp_out3_result", out_result, 32'h33);
    tick();
    chk("bp_drained", out_valid, 0);
    chk("bp_op_count", op_count, 3);
    chk("bp_sat_count", s_op_count, 3);

    // Reset with two operations in flight
    out_ready = 1'b0;
    in_op = 4'd0; in_a = 32'd7; in_b = 32'd8; in_tag = 4'd5; in_valid = 1'b1;
    tick();
    in_tag = 4'd6;
    tick();
    in_valid = 1'b0;
    chk("mid_pre_valid", out_valid, 1);
    do_reset();
    #1;
    chk("mid_out_valid", out_valid, 0);
    chk("mid_op_count", op_count, 0);
    chk("mid_in_ready", in_ready, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mid_no_stale", out_valid, 0);
    end
    chk("mid_count_after", op_count, 0);

    // Streaming: 100 random ops, random out_ready, checked in order against the model
    for (int i = 0; i < 100; i++) begin
      st_op[i] = ($urandom_range(0, 9) == 9) ? 4'($urandom_range(9, 15))
                                              : 4'($urandom_range(0, 8));
      st_a[i]  = $urandom;
      st_b[i]  = (i % 7 == 0) ? st_a[i] : $urandom;
    end
    do_reset();
    sent = 0; recv = 0; cycles = 0;
    while (recv < 100 && cycles < 3000) begin
      out_ready = (sent >= 100) ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid  = (sent < 100);
      if (sent < 100) begin
        in_op = st_op[sent]; in_a = st_a[sent]; in_b = st_b[sent]; in_tag = 4'(sent);
      end
      #1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stream_unexpected_out", out_valid, 0);
        end else begin
          front = exp_q.pop_front();
          chk("stream_result", out_result, front[31:0]);
          chk("stream_flags", out_flags, front[35:32]);
          chk("stream_tag", out_tag, front[39:36]);
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({4'(sent), model(st_op[sent], st_a[sent], st_b[sent])});
        sent++;
      end
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    chk("stream_finished_in_budget", recv, 100);
    chk("stream_queue_empty", exp_q.size(), 0);
    tick();
    chk("stream_op_count", op_count, 100);
    chk("stream_sat_count", s_op_count, 15);
    chk("stream_drained", out_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
